// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite stored in an external synchronous ROM and
// streams one pixel per cycle to the VGA adapter write port. Supports a
// transparent colour key, horizontal mirroring, erase fill and screen clipping.
//
// state   | meaning
// S_IDLE  | waiting for start, inputs latched on acceptance
// S_FETCH | one ROM address per cycle, ox fastest, oy slowest
// S_DRAIN | ROM and output stages emptying (ROM_LAT+1 cycles)
// S_DONE  | one-cycle done pulse, then back to idle
module sprite_blitter #(
  parameter int SPR_W     = 28,
  parameter int SPR_H     = 20,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int COL_W     = 3,
  parameter int ADDR_W    = 10,
  parameter int ROM_LAT   = 1,
  parameter int SCR_W     = 320,
  parameter int SCR_H     = 240,
  parameter int TRANS_COL = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [X_W-1:0]    x_base_i,
  input  logic [Y_W-1:0]    y_base_i,
  input  logic [1:0]        mode_i,
  input  logic [COL_W-1:0]  erase_col_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [COL_W-1:0]  rom_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              plot_o,
  output logic [X_W-1:0]    plot_x_o,
  output logic [Y_W-1:0]    plot_y_o,
  output logic [COL_W-1:0]  plot_col_o
);

  localparam int OX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int OY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DR_W = $clog2(ROM_LAT + 1);

  localparam logic [OX_W-1:0]   OX_LAST  = OX_W'(SPR_W - 1);
  localparam logic [OY_W-1:0]   OY_LAST  = OY_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SPR_W - 1);
  localparam logic [DR_W-1:0]   DR_INIT  = DR_W'(ROM_LAT);
  localparam logic [X_W:0]      SCR_W_L  = (X_W + 1)'(SCR_W);
  localparam logic [Y_W:0]      SCR_H_L  = (Y_W + 1)'(SCR_H);
  localparam logic [COL_W-1:0]  TRANS_L  = COL_W'(TRANS_COL);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [OX_W-1:0]   ox_q;
  logic [OY_W-1:0]   oy_q;
  logic [ADDR_W-1:0] row_q;     // oy*SPR_W kept incrementally, avoids a multiplier
  logic [DR_W-1:0]   drain_q;
  logic [X_W-1:0]    xb_q;
  logic [Y_W-1:0]    yb_q;
  logic              mirror_q;
  logic              erase_q;
  logic [COL_W-1:0]  ecol_q;
  logic              busy_q;
  logic              done_q;

  logic [OX_W-1:0]    ox_pipe_q [ROM_LAT];
  logic [OY_W-1:0]    oy_pipe_q [ROM_LAT];
  logic [ROM_LAT-1:0] vld_pipe_q;

  logic              plot_q;
  logic [X_W-1:0]    px_q;
  logic [Y_W-1:0]    py_q;
  logic [COL_W-1:0]  col_q;

  logic [ADDR_W-1:0] ox_ext;
  logic [ADDR_W-1:0] addr_d;
  logic [X_W:0]      px_d;
  logic [Y_W:0]      py_d;
  logic              vis_d;
  logic [COL_W-1:0]  col_d;

  assign ox_ext = ADDR_W'(ox_q);

  // ROM address from the walk counters; parked at zero outside the fetch phase
  always_comb begin
    addr_d = '0;
    if (state_q == S_FETCH) begin
      addr_d = mirror_q ? (row_q + (COL_LAST - ox_ext)) : (row_q + ox_ext);
    end
  end

  assign rom_addr_o = addr_d;

  // Screen position and visibility of the pixel whose ROM data is arriving now
  always_comb begin
    px_d  = (X_W + 1)'(xb_q) + (X_W + 1)'(ox_pipe_q[ROM_LAT-1]);
    py_d  = (Y_W + 1)'(yb_q) + (Y_W + 1)'(oy_pipe_q[ROM_LAT-1]);
    vis_d = vld_pipe_q[ROM_LAT-1] && (px_d < SCR_W_L) && (py_d < SCR_H_L) &&
            (erase_q || (rom_q_i != TRANS_L));
    col_d = erase_q ? ecol_q : rom_q_i;
  end

  // Control FSM: accepts start, walks the sprite, drains, pulses done
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      row_q    <= '0;
      drain_q  <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      mirror_q <= 1'b0;
      erase_q  <= 1'b0;
      ecol_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_FETCH;
            ox_q     <= '0;
            oy_q     <= '0;
            row_q    <= '0;
            xb_q     <= x_base_i;
            yb_q     <= y_base_i;
            mirror_q <= (mode_i == 2'b01);
            erase_q  <= mode_i[1];
            ecol_q   <= erase_col_i;
            busy_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (ox_q == OX_LAST) begin
            ox_q <= '0;
            if (oy_q == OY_LAST) begin
              state_q <= S_DRAIN;
              drain_q <= DR_INIT;
            end else begin
              oy_q  <= oy_q + 1'b1;
              row_q <= row_q + ROW_STEP;
            end
          end else begin
            ox_q <= ox_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Delay the pixel coordinates and valid flag to line up with rom_q
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        ox_pipe_q[i] <= '0;
        oy_pipe_q[i] <= '0;
      end
    end else begin
      vld_pipe_q[0] <= (state_q == S_FETCH);
      ox_pipe_q[0]  <= ox_q;
      oy_pipe_q[0]  <= oy_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        ox_pipe_q[i]  <= ox_pipe_q[i-1];
        oy_pipe_q[i]  <= oy_pipe_q[i-1];
      end
    end
  end

  // Registered plot port; coordinates and colour hold while no pixel is written
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      plot_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
    end else begin
      plot_q <= vis_d;
      if (vis_d) begin
        px_q  <= px_d[X_W-1:0];
        py_q  <= py_d[Y_W-1:0];
        col_q <= col_d;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign plot_o     = plot_q;
  assign plot_x_o   = px_q;
  assign plot_y_o   = py_q;
  assign plot_col_o = col_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (ROM latency 1 and 2) with bench ROMs;
// expected pixels are queued when a render starts and popped as plots arrive.
module tb_sprite_blitter;
  localparam int W = 28;
  localparam int H = 20;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       st1, st2;
  logic [8:0] xb;
  logic [7:0] yb;
  logic [1:0] md;
  logic [2:0] ec;

  logic [9:0] ra1, ra2;
  logic [2:0] rq1, rq2, r2a;
  logic       busy1, done1, plot1, busy2, done2, plot2;
  logic [8:0] px1, px2;
  logic [7:0] py1, py2;
  logic [2:0] pc1, pc2;

  sprite_blitter #(.ROM_LAT(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(st1), .x_base_i(xb), .y_base_i(yb),
    .mode_i(md), .erase_col_i(ec), .rom_addr_o(ra1), .rom_q_i(rq1),
    .busy_o(busy1), .done_o(done1), .plot_o(plot1), .plot_x_o(px1),
    .plot_y_o(py1), .plot_col_o(pc1));

  sprite_blitter #(.ROM_LAT(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .start_i(st2), .x_base_i(xb), .y_base_i(yb),
    .mode_i(md), .erase_col_i(ec), .rom_addr_o(ra2), .rom_q_i(rq2),
    .busy_o(busy2), .done_o(done2), .plot_o(plot2), .plot_x_o(px2),
    .plot_y_o(py2), .plot_col_o(pc2));

  always #5 clk = ~clk;

  int rom_mode = 0;
  function automatic logic [2:0] rom_val(input logic [9:0] a);
    case (rom_mode)
      0:       return 3'd5;
      1:       return a[2:0];
      default: return 3'd0;
    endcase
  endfunction

  // bench ROMs: latency 1 for dut1, latency 2 for dut2
  always @(posedge clk) begin
    rq1 <= rom_val(ra1);
    r2a <= rom_val(ra2);
    rq2 <= r2a;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel = 0;
  logic       m_plot, m_busy, m_done;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic [2:0] m_col;
  logic [9:0] m_addr;
  assign m_plot = sel ? plot2 : plot1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_x    = sel ? px2 : px1;
  assign m_y    = sel ? py2 : py1;
  assign m_col  = sel ? pc2 : pc1;
  assign m_addr = sel ? ra2 : ra1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {int c; int x; int y; int col;} exp_t;
  exp_t q[$];
  int   c0 = 0;
  bit   mon_en = 1'b0;
  int   mon_cnt = 0;

  // scoreboard consumer
  always @(negedge clk) begin
    if (mon_en && m_plot) begin
      mon_cnt++;
      if (q.size() == 0) begin
        chk("extra_plot", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("plot_cycle", cyc - c0, e.c);
        chk("plot_x", m_x, e.x);
        chk("plot_y", m_y, e.y);
        chk("plot_col", m_col, e.col);
      end
    end
  end

  task automatic push_model(input int x0, input int y0, input int mode, input int ecol, input int lat);
    bit mir, er;
    int addr, col, px, py;
    mir = (mode == 1);
    er  = (mode >= 2);
    for (int oy = 0; oy < H; oy++) begin
      for (int ox = 0; ox < W; ox++) begin
        addr = mir ? oy * W + (W - 1 - ox) : oy * W + ox;
        col  = er ? ecol : int'(rom_val(10'(addr)));
        px   = x0 + ox;
        py   = y0 + oy;
        if (px < 320 && py < 240 && (er || col != 0))
          q.push_back('{oy * W + ox + lat + 2, px, py, col});
      end
    end
  endtask

  task automatic start_render(input int s, input int x0, input int y0, input int mode,
                              input int ecol, input int rm, input int lat);
    @(posedge clk); #1;
    sel      = s;
    rom_mode = rm;
    xb = 9'(x0); yb = 8'(y0); md = 2'(mode); ec = 3'(ecol);
    q.delete();
    push_model(x0, y0, mode, ecol, lat);
    mon_cnt = 0;
    mon_en  = 1'b1;
    c0 = cyc;
    if (s == 0) st1 = 1'b1; else st2 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; st2 = 1'b0;
    // scramble inputs: the DUT must have latched them
    xb = ~xb; yb = ~yb; md = ~md; ec = ~ec;
  endtask

  task automatic run(input int s, input int x0, input int y0, input int mode,
                     input int ecol, input int rm, input int exp_cnt, input int lat);
    int rel;
    start_render(s, x0, y0, mode, ecol, rm, lat);
    for (int i = 0; i < N + lat + 6; i++) begin
      @(negedge clk);
      rel = cyc - c0;
      chk("busy", m_busy, 32'((rel >= 1) && (rel <= N + lat + 2)));
      chk("done", m_done, 32'(rel == N + lat + 2));
      if (rel == 1) chk("addr_first", m_addr, (mode == 1) ? W - 1 : 0);
      if (rel == 2) chk("addr_second", m_addr, (mode == 1) ? W - 2 : 1);
      if (rel == N + 1) chk("addr_parked", m_addr, 0);
    end
    mon_en = 1'b0;
    chk("plot_count", mon_cnt, exp_cnt);
    chk("queue_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic reset_test();
    start_render(0, 50, 60, 0, 0, 0, 1);
    for (int i = 0; i < 99; i++) begin
      @(posedge clk); #1;
      st1 = ((cyc - c0) == 50);
      chk("busy_pre_rst", busy1, 1);
      chk("done_pre_rst", done1, 0);
    end
    rst = 1'b1;
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_plot", plot1, 0);
    chk("rst_x", px1, 0);
    chk("rst_y", py1, 0);
    chk("rst_col", pc1, 0);
    chk("rst_addr", ra1, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk("post_rst_done", done1, 0);
      chk("post_rst_busy", busy1, 0);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st1 = 1'b0; st2 = 1'b0;
    xb = '0; yb = '0; md = '0; ec = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy1, 0);
    chk("init_done", done1, 0);
    chk("init_plot", plot1, 0);
    chk("init_x", px1, 0);
    chk("init_y", py1, 0);
    chk("init_col", pc1, 0);
    chk("init_addr", ra1, 0);
    chk("init_busy2", busy2, 0);
    chk("init_plot2", plot2, 0);
    rst = 1'b0;

    run(0, 10, 20, 0, 0, 0, 560, 1);
    run(0, 10, 20, 0, 0, 1, 490, 1);
    run(0, 0, 0, 1, 0, 1, 490, 1);
    run(0, 5, 7, 2, 3, 2, 560, 1);
    run(0, 100, 100, 3, 6, 1, 560, 1);
    run(0, 300, 230, 0, 0, 0, 200, 1);
    reset_test();
    run(0, 1, 2, 0, 0, 0, 560, 1);
    run(1, 10, 20, 0, 0, 0, 560, 2);
    run(1, 0, 0, 1, 0, 1, 490, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
